// File: rtl/acc_sequencer.sv
// acc_sequencer: multi-cycle accumulator control FSM (load/mem-wait/ALU-wait/writeback, halt, error).
// Define ACC_SEQ_PERF_EN to add the retire_count/stall_count performance counters.
module acc_sequencer #(
    parameter int ALU_LAT     = 2,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [2:0] instr_op,
    output logic       instr_ready,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       alu_start,
    output logic [1:0] data_ctrl,
    output logic       write_ctrl,
    output logic       reg_write,
    output logic       retire,
    output logic       halted,
    output logic       error
`ifdef ACC_SEQ_PERF_EN
    ,
    output logic [15:0] retire_count,
    output logic [15:0] stall_count
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MEM_WAIT, S_ALU_WAIT, S_WB, S_HALTED, S_ERROR} state_t;
    localparam logic [2:0] OP_LDI = 3'd0, OP_LDR = 3'd1, OP_LDM = 3'd2, OP_ALU = 3'd3;
    localparam logic [2:0] OP_STA = 3'd4, OP_NOP = 3'd5, OP_HALT = 3'd6, OP_RSV = 3'd7;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_op, w_op_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [9:0] r_out;

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: if (instr_valid) begin
                w_state_nxt = S_EXEC;
                w_op_nxt    = instr_op;
            end
            S_EXEC: begin
                w_cnt_nxt = '0;
                case (r_op)
                    OP_LDM:  w_state_nxt = S_MEM_WAIT;
                    OP_ALU:  w_state_nxt = (ALU_LAT == 1) ? S_WB : S_ALU_WAIT;
                    OP_HALT: w_state_nxt = S_HALTED;
                    OP_RSV:  w_state_nxt = S_ERROR;
                    default: w_state_nxt = S_IDLE;
                endcase
            end
            // mem_ready takes priority over a timeout landing on the same cycle
            S_MEM_WAIT: begin
                w_state_nxt = mem_ready ? S_WB : (r_cnt == 8'(MEM_TIMEOUT - 1)) ? S_ERROR : S_MEM_WAIT;
                w_cnt_nxt   = r_cnt + 8'd1;
            end
            S_ALU_WAIT: begin
                w_state_nxt = (r_cnt == 8'(ALU_LAT - 2)) ? S_WB : S_ALU_WAIT;
                w_cnt_nxt   = r_cnt + 8'd1;
            end
            S_WB:      w_state_nxt = S_IDLE;
            S_HALTED:  w_state_nxt = S_HALTED;
            S_ERROR:   w_state_nxt = S_ERROR;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered value matches the state it lands in
    logic       w_exec, w_wb, w_ready, w_mem_read, w_alu_start, w_write, w_reg_write, w_retire;
    logic [1:0] w_data_ctrl;
    assign w_exec      = w_state_nxt == S_EXEC;
    assign w_wb        = w_state_nxt == S_WB;
    assign w_ready     = w_state_nxt == S_IDLE;
    assign w_mem_read  = (w_exec && w_op_nxt == OP_LDM) || w_state_nxt == S_MEM_WAIT;
    assign w_alu_start = w_exec && w_op_nxt == OP_ALU;
    assign w_write     = (w_exec && (w_op_nxt == OP_LDI || w_op_nxt == OP_LDR)) || w_wb;
    assign w_reg_write = w_exec && w_op_nxt == OP_STA;
    assign w_retire    = (w_exec && (w_op_nxt inside {OP_LDI, OP_LDR, OP_STA, OP_NOP, OP_HALT})) || w_wb;
    assign w_data_ctrl = w_wb ? ((w_op_nxt == OP_ALU) ? 2'd3 : 2'd2) :
                         (w_write && w_op_nxt == OP_LDR) ? 2'd1 : 2'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
            r_out   <= 10'h200;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= {w_ready, w_mem_read, w_alu_start, w_data_ctrl, w_write, w_reg_write, w_retire,
                        w_state_nxt == S_HALTED, w_state_nxt == S_ERROR};
        end
    end

    assign {instr_ready, mem_read, alu_start, data_ctrl, write_ctrl, reg_write, retire, halted, error} = r_out;

`ifdef ACC_SEQ_PERF_EN
    logic [15:0] r_retire_count, r_stall_count;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_retire_count <= '0;
            r_stall_count  <= '0;
        end else begin
            r_retire_count <= r_retire_count + 16'(r_out[2]);
            r_stall_count  <= r_stall_count + 16'(r_state == S_MEM_WAIT || r_state == S_ALU_WAIT);
        end
    end
    assign retire_count = r_retire_count;
    assign stall_count  = r_stall_count;
`endif
endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: vector table, directed corner sequences and a randomized transaction model.
module tb_acc_sequencer;
    localparam int ALU_LAT = 2;
    localparam int MEM_TIMEOUT = 8;
    localparam logic [9:0] RDY = 10'h200, MR = 10'h100, AS = 10'h080, DC1 = 10'h020, DC2 = 10'h040,
                           DC3 = 10'h060, W = 10'h010, RW = 10'h008, RT = 10'h004, H = 10'h002, E = 10'h001;

    logic       clk = 0;
    logic       rst_n = 0, instr_valid = 0, mem_ready = 0;
    logic [2:0] instr_op = 0;
    logic       instr_ready, mem_read, alu_start, write_ctrl, reg_write, retire, halted, error;
    logic [1:0] data_ctrl;
    logic [9:0] w_out;
    int         n_tests = 0, n_fail = 0;

    acc_sequencer #(.ALU_LAT(ALU_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_op(instr_op),
        .instr_ready(instr_ready), .mem_ready(mem_ready), .mem_read(mem_read), .alu_start(alu_start),
        .data_ctrl(data_ctrl), .write_ctrl(write_ctrl), .reg_write(reg_write), .retire(retire),
        .halted(halted), .error(error)
    );

    always #5 clk = ~clk;
    assign w_out = {instr_ready, mem_read, alu_start, data_ctrl, write_ctrl, reg_write, retire, halted, error};

    task automatic step(input logic rn, input logic v, input logic [2:0] o, input logic mr,
                        input logic [9:0] exp, input string nm);
        rst_n = rn; instr_valid = v; instr_op = o; mem_ready = mr;
        @(posedge clk); #1;
        n_tests++;
        if (w_out !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs=%h expected=%h", nm, w_out, exp);
        end
    endtask

    // Expected outputs k cycles after acceptance; LDM sees mem_ready on its d-th wait cycle
    function automatic logic [9:0] model(input logic [2:0] op, input int d, input int k);
        case (op)
            3'd0: return k == 1 ? (W | RT) : RDY;
            3'd1: return k == 1 ? (W | DC1 | RT) : RDY;
            3'd2: if (d <= MEM_TIMEOUT) return k <= d + 1 ? MR : k == d + 2 ? (W | DC2 | RT) : RDY;
                  else return k <= MEM_TIMEOUT + 1 ? MR : E;
            3'd3: return k == 1 ? AS : k <= ALU_LAT ? 10'h0 : k == ALU_LAT + 1 ? (W | DC3 | RT) : RDY;
            3'd4: return k == 1 ? (RW | RT) : RDY;
            3'd5: return k == 1 ? RT : RDY;
            3'd6: return k == 1 ? RT : H;
            default: return k == 1 ? 10'h0 : E;
        endcase
    endfunction

    function automatic int txn_len(input logic [2:0] op, input int d);
        case (op)
            3'd2: return d <= MEM_TIMEOUT ? d + 3 : MEM_TIMEOUT + 3;
            3'd3: return ALU_LAT + 2;
            3'd6, 3'd7: return 3;
            default: return 2;
        endcase
    endfunction

    typedef struct {logic rn; logic v; logic [2:0] op; logic mr; logic [9:0] exp;} vec_t;
    vec_t tbl[21];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, RDY};
        tbl[1]  = '{1'b1, 1'b1, 3'd0, 1'b0, W | RT};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 1'b0, RDY};
        tbl[3]  = '{1'b1, 1'b1, 3'd1, 1'b0, W | DC1 | RT};
        tbl[4]  = '{1'b1, 1'b1, 3'd4, 1'b0, RDY};
        tbl[5]  = '{1'b1, 1'b1, 3'd4, 1'b0, RW | RT};
        tbl[6]  = '{1'b1, 1'b1, 3'd6, 1'b0, RDY};
        tbl[7]  = '{1'b1, 1'b1, 3'd6, 1'b0, RT};
        tbl[8]  = '{1'b1, 1'b1, 3'd0, 1'b0, H};
        tbl[9]  = '{1'b1, 1'b1, 3'd0, 1'b0, H};
        tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b0, RDY};
        tbl[11] = '{1'b1, 1'b1, 3'd3, 1'b0, AS};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 1'b0, 10'h0};
        tbl[13] = '{1'b1, 1'b0, 3'd0, 1'b0, W | DC3 | RT};
        tbl[14] = '{1'b1, 1'b0, 3'd0, 1'b0, RDY};
        tbl[15] = '{1'b1, 1'b1, 3'd5, 1'b0, RT};
        tbl[16] = '{1'b1, 1'b1, 3'd7, 1'b0, RDY};
        tbl[17] = '{1'b1, 1'b1, 3'd7, 1'b0, 10'h0};
        tbl[18] = '{1'b1, 1'b0, 3'd0, 1'b0, E};
        tbl[19] = '{1'b1, 1'b1, 3'd0, 1'b0, E};
        tbl[20] = '{1'b0, 1'b0, 3'd0, 1'b0, RDY};
        for (int i = 0; i < 21; i++)
            step(tbl[i].rn, tbl[i].v, tbl[i].op, tbl[i].mr, tbl[i].exp, $sformatf("vec%0d", i));

        // LDM, mem_ready on the third wait cycle
        step(1, 1, 3'd2, 0, MR, "ldm_exec");
        step(1, 0, 3'd0, 0, MR, "ldm_w1");
        step(1, 0, 3'd0, 0, MR, "ldm_w2");
        step(1, 0, 3'd0, 0, MR, "ldm_w3");
        step(1, 0, 3'd0, 1, W | DC2 | RT, "ldm_wb");
        step(1, 0, 3'd0, 0, RDY, "ldm_idle");

        // LDM timeout, error is sticky until reset
        step(1, 1, 3'd2, 0, MR, "to_exec");
        for (int i = 1; i <= MEM_TIMEOUT; i++) step(1, 0, 3'd0, 0, MR, "to_wait");
        step(1, 0, 3'd0, 0, E, "to_err");
        step(1, 1, 3'd0, 0, E, "to_sticky");
        step(0, 0, 3'd0, 0, RDY, "to_rst");

        // mem_ready on the very cycle the timeout would fire
        step(1, 1, 3'd2, 0, MR, "tie_exec");
        for (int i = 1; i <= MEM_TIMEOUT; i++) step(1, 0, 3'd0, 0, MR, "tie_wait");
        step(1, 0, 3'd0, 1, W | DC2 | RT, "tie_wb");
        step(1, 0, 3'd0, 0, RDY, "tie_idle");

        // Reset in ALU_WAIT aborts the writeback
        step(1, 1, 3'd3, 0, AS, "arst_exec");
        step(1, 0, 3'd0, 0, 10'h0, "arst_wait");
        step(0, 0, 3'd0, 0, RDY, "arst_rst");
        step(1, 0, 3'd0, 0, RDY, "arst_after");

        for (int t = 0; t < 300; t++) begin
            logic [2:0] op;
            int d, len;
            op = 3'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0) op = 3'($urandom_range(6, 7));
            d = $urandom_range(1, MEM_TIMEOUT + 2);
            len = txn_len(op, d);
            step(1, 1, op, 0, model(op, d, 1), "rnd_accept");
            for (int k = 2; k <= len; k++)
                step(1, 1'($urandom), 3'($urandom), op == 3'd2 && k == d + 2, model(op, d, k), "rnd");
            if (op >= 3'd6 || (op == 3'd2 && d > MEM_TIMEOUT))
                step(0, 0, 3'd0, 0, RDY, "rnd_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/acc_sequencer.md
Name: acc_sequencer

Overview:
Multi-cycle control FSM that drives the accumulator's source select (data_ctrl) and write enable (write_ctrl) from a decoded instruction class. It accepts one instruction per valid/ready handshake and sequences the memory-load wait, the fixed-latency ALU wait and the writeback cycle. It also flags halt and error conditions. It sits between the instruction decoder and the accumulator/ALU/data-memory datapath.

Parameters:
ALU_LAT, 2, cycles from alu_start to a valid ALU result (legal range 1..15).
MEM_TIMEOUT, 8, maximum MEM_WAIT cycles without mem_ready before error (legal range 1..255).

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
instr_valid  input  1  decoder presents an instruction.
instr_op  input  3  instruction class: 000 LDI, 001 LDR, 010 LDM, 011 ALU, 100 STA, 101 NOP, 110 HALT, 111 reserved.
instr_ready  output  1  sequencer can accept an instruction this cycle.
mem_ready  input  1  data memory read data valid this cycle.
mem_read  output  1  data memory read request.
alu_start  output  1  one-cycle ALU launch pulse.
data_ctrl  output  2  accumulator source select: 0 imm, 1 reg, 2 mem, 3 alu.
write_ctrl  output  1  accumulator write enable.
reg_write  output  1  register file write of the accumulator value (STA).
retire  output  1  one-cycle pulse per completed instruction.
halted  output  1  sticky halt flag.
error  output  1  sticky error flag.

Behaviour:
- All outputs are registered. Reset value of every output is 0, except instr_ready, which is 1. State resets to IDLE. Reset wins over all other events, including mid-operation and in HALTED or ERROR.
- States: IDLE, EXEC, MEM_WAIT, ALU_WAIT, WB, HALTED, ERROR.
- IDLE: instr_ready=1. An instruction is accepted on instr_valid && instr_ready; instr_op is latched and the FSM moves to EXEC. instr_ready drops the cycle after acceptance.
- EXEC, one cycle, decoded by the latched op:
  - LDI, LDR: write_ctrl=1, data_ctrl=0 or 1, retire=1; next IDLE. The write is visible the cycle after acceptance.
  - STA: reg_write=1, write_ctrl=0, retire=1; next IDLE.
  - NOP: retire=1; next IDLE.
  - LDM: mem_read=1; next MEM_WAIT with wait counter cleared.
  - ALU: alu_start=1; next ALU_WAIT with counter cleared.
  - HALT: retire=1; next HALTED.
  - reserved (111): next ERROR. No retire.
- MEM_WAIT:
  - mem_read is held at 1.
  - mem_ready=1 leads to WB with source 2; mem_read drops on the WB cycle.
  - Each cycle without mem_ready increments the counter. When the counter reaches MEM_TIMEOUT, next state is ERROR.
  - If mem_ready arrives on the same cycle the counter reaches MEM_TIMEOUT, mem_ready wins and the FSM goes to WB.
- ALU_WAIT: counts ALU_LAT-1 cycles after the alu_start cycle, then goes to WB with source 3. The alu_start pulse is exactly one cycle wide.
- WB, one cycle: write_ctrl=1, data_ctrl set to the latched source, retire=1; next IDLE.
- data_ctrl reads 0 whenever write_ctrl=0.
- Mutual exclusion: write_ctrl and reg_write are never both 1 in the same cycle.
- HALTED: halted=1, instr_ready=0, all other outputs 0. Exit only by reset.
- ERROR: error=1, instr_ready=0, all other outputs 0. Exit only by reset.
- Latency from acceptance to the accumulator write:
  - LDI/LDR: 1 cycle.
  - LDM: 2 + (mem_ready wait) cycles.
  - ALU: 1 + ALU_LAT cycles.
- Back-to-back issue: minimum issue interval is 2 cycles, because instr_ready is 0 in every non-IDLE state.
- instr_valid while instr_ready=0 is ignored. The decoder must hold the instruction until it is accepted.

Optional Feature:
ACC_SEQ_PERF_EN
- Defined: adds output retire_count (16-bit) and output stall_count (16-bit).
  - retire_count increments on every retire pulse.
  - stall_count increments on every MEM_WAIT or ALU_WAIT cycle.
  - Both counters wrap at 0xFFFF to 0 and clear on reset.
- Undefined: neither port nor counter logic exists. All other behaviour is identical.

Test Plan:
- Reset, then LDI (op=000) accepted at cycle 0 -> write_ctrl=1, data_ctrl=0, retire=1 at cycle 1; instr_ready=1 at cycle 2.
- LDM with mem_ready asserted 3 cycles after mem_read rises -> mem_read high for 4 cycles, then a WB cycle with data_ctrl=2, write_ctrl=1.
- LDM with mem_ready held 0 and MEM_TIMEOUT=8 -> error=1 after 8 MEM_WAIT cycles; instr_ready stays 0 until rst_n=0 clears error.
- ALU op with ALU_LAT=2 accepted at cycle 0 -> alu_start=1 at cycle 1 only; write_ctrl=1, data_ctrl=3 at cycle 3.
- STA followed by HALT, each with instr_valid held -> reg_write=1 with write_ctrl=0 for STA; HALT retires, halted=1 latches, and further instr_valid is not accepted.
- rst_n driven low during ALU_WAIT -> on the next edge all outputs are at reset values and instr_ready=1. With ACC_SEQ_PERF_EN, retire_count=0.
